compare_arbiter: RTL and testbench

//  Shares one registered magnitude comparator between NUM_REQ requesters.
//  - Arbitration is round-robin; each request is a valid/ready handshake.
//  - Operands are latched, compared, and the one-hot E/G/L result is returned
//    to the winning requester over a valid/ready response channel.
//  - Sits between the compare clients and the comparator datapath.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/compare_core.sv | 48 ++++
 rtl/compare_arbiter.sv | 152 +++++++++++++++
 tb/tb_compare_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the compare arbiter: FSM state encoding and the one-hot
// comparison result carried from the comparator core to the response port.
package cmp_pkg;

    localparam int RES_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } res_t;

endpackage

// File: rtl/compare_core.sv
// Registered magnitude comparator producing a one-hot {eq, gt, lt} result.
// Build option CMP_SIGNED_EN: when defined, operands are treated as two's
// complement; otherwise they are compared as unsigned values.
import cmp_pkg::*;

module compare_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output res_t             res
);

    logic w_eq;
    logic w_gt;
    logic w_lt;
    res_t r_res;

`ifdef CMP_SIGNED_EN
    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;

    assign w_sa = $signed(a);
    assign w_sb = $signed(b);
    assign w_gt = (w_sa > w_sb);
    assign w_lt = (w_sa < w_sb);
`else
    assign w_gt = (a > b);
    assign w_lt = (a < b);
`endif

    assign w_eq = (a == b);

    // Capture the comparison only when enabled so the result holds through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
        end else if (en) begin
            r_res <= '{eq: w_eq, gt: w_gt, lt: w_lt};
        end
    end

    assign res = r_res;

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin arbiter sharing one registered comparator among NUM_REQ
// requesters. A granted request has its operands latched, compared in the
// CMP state and the result is returned on the winner's response channel.
// Build option CMP_SIGNED_EN selects signed comparison inside compare_core.
import cmp_pkg::*;

module compare_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     rsp_eq,
    output logic                     rsp_gt,
    output logic                     rsp_lt,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant;
    logic [IDW-1:0]     w_winner;
    logic               w_found;
    logic               w_hs;
    logic               w_core_en;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [NUM_REQ-1:0] w_rsp_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   w_a_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_b_arr [NUM_REQ];
    res_t               w_res;

    // Requester index base+off, wrapping at NUM_REQ (also valid for non powers of 2)
    function automatic logic [IDW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = (base + off) % NUM_REQ;
        return IDW'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign w_b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search: first valid requester starting at the pointer
    always_comb begin
        logic [IDW-1:0] v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = wrap_idx(int'(r_rr_ptr), k);
            if (!w_found && req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state, request accept and comparator enable
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_hs        = 1'b0;
        w_core_en   = 1'b0;
        case (r_state)
            IDLE: begin
                // Held off during reset so every output reads 0 while rst is high
                if (w_found && !rst) begin
                    w_req_ready[w_winner] = 1'b1;
                    w_hs                  = 1'b1;
                    w_next                = CMP;
                end
            end
            CMP: begin
                w_core_en = 1'b1;
                w_next    = RESP;
            end
            RESP: begin
                // Only the granted requester can retire the response
                if (rsp_ready[r_grant]) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping and operand latch, updated only on the request handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= wrap_idx(int'(w_winner), 1);
            r_grant  <= w_winner;
            r_a      <= w_a_arr[w_winner];
            r_b      <= w_b_arr[w_winner];
        end
    end

    compare_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_core_en),
        .a   (r_a),
        .b   (r_b),
        .res (w_res)
    );

    // Steer the response valid to the granted requester while in RESP
    always_comb begin
        w_rsp_valid = '0;
        if (r_state == RESP) begin
            w_rsp_valid[r_grant] = 1'b1;
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_eq    = (r_state == RESP) && w_res.eq;
    assign rsp_gt    = (r_state == RESP) && w_res.gt;
    assign rsp_lt    = (r_state == RESP) && w_res.lt;
    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: a transaction-level reference model checks all
// outputs every cycle, and directed scenarios pin literal expectations.
module tb_compare_arbiter;

    localparam int N   = 4;
    localparam int W   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic           rsp_eq;
    logic           rsp_gt;
    logic           rsp_lt;
    logic [IDW-1:0] grant_id;
    logic           busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    compare_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected {eq,gt,lt} from the numeric values of the operands
    function automatic int exp_res(input int a, input int b);
`ifdef CMP_SIGNED_EN
        if (a >= (1 << (W-1))) a = a - (1 << W);
        if (b >= (1 << (W-1))) b = b - (1 << W);
`endif
        if (a == b) return 4;
        if (a > b)  return 2;
        return 1;
    endfunction

    function automatic int op_of(input logic [N*W-1:0] v, input int i);
        return int'(v[i*W +: W]);
    endfunction

    function automatic int dut_res();
        return int'({rsp_eq, rsp_gt, rsp_lt});
    endfunction

    // Reference model: transaction view with pointer, pending grant and a
    // count of cycles elapsed since the grant
    initial begin
        int m_ptr, m_gid, m_res, m_age;
        bit m_active;
        m_ptr = 0; m_gid = 0; m_res = 0; m_age = 0; m_active = 0;
        forever begin
            int e_rr, e_rv, e_res, e_busy, win;
            @(negedge clk);
            e_rr = 0; e_rv = 0; e_res = 0; e_busy = 0; win = -1;
            if (rst) begin
                m_ptr = 0; m_gid = 0; m_active = 0; m_age = 0;
            end else if (!m_active) begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
                if (win >= 0) e_rr = 1 << win;
            end else begin
                e_busy = 1;
                if (m_age >= 2) begin
                    e_rv  = 1 << m_gid;
                    e_res = m_res;
                end
            end
            check("m_req_ready", int'(req_ready), e_rr);
            check("m_rsp_valid", int'(rsp_valid), e_rv);
            check("m_result",    dut_res(),       e_res);
            check("m_grant_id",  int'(grant_id),  m_gid);
            check("m_busy",      int'(busy),      e_busy);
            if (!rst) begin
                if (!m_active && win >= 0) begin
                    m_gid    = win;
                    m_ptr    = (win + 1) % N;
                    m_res    = exp_res(op_of(req_a, win), op_of(req_b, win));
                    m_active = 1;
                    m_age    = 1;
                end else if (m_active) begin
                    if (m_age >= 2 && rsp_ready[m_gid]) m_active = 0;
                    else m_age++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise requester i with its operands and drop it right after the handshake
    task automatic issue(input int i, input int a, input int b);
        bit seen;
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_valid[i] = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (req_ready[i]) seen = 1;
        end
        check("grant_seen", int'(seen), 1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!busy && rsp_valid == '0) done = 1;
        end
        check("idle_reached", int'(done), 1);
    endtask

    task automatic run_one(input int i, input int a, input int b, input int er);
        step();
        issue(i, a, b);
        @(negedge clk);
        @(negedge clk);
        check("lit_rsp_valid", int'(rsp_valid), 1 << i);
        check("lit_result",    dut_res(),       er);
        check("lit_grant_id",  int'(grant_id),  i);
        wait_idle();
    endtask

    initial begin
        int ids[$];
        int cycs[$];
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;

        // Reset state
        @(negedge clk);
        check("rst_busy",      int'(busy),      0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_grant_id",  int'(grant_id),  0);
        step();
        rst = 1'b0;

        // Single requester 2: 9 > 3
        run_one(2, 4'h9, 4'h3, 2);

        // All four requesting from reset, rsp_ready always high
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_a = 16'h1234;
        req_b = 16'h4321;
        req_valid = '1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                ids.push_back(int'(grant_id));
                cycs.push_back(cyc);
            end
        end
        step();
        req_valid = '0;
        check("rr_count", ids.size(), 5);
        if (ids.size() >= 5) begin
            check("rr_order0", ids[0], 0);
            check("rr_order1", ids[1], 1);
            check("rr_order2", ids[2], 2);
            check("rr_order3", ids[3], 3);
            check("rr_order4", ids[4], 0);
            for (int k = 1; k < 5; k++) check("rr_spacing", cycs[k] - cycs[k-1], 3);
        end
        wait_idle();

        // Equal, less-than and the signed/unsigned boundary
        run_one(0, 4'hF, 4'hF, 4);
        run_one(0, 4'h0, 4'h1, 1);
`ifdef CMP_SIGNED_EN
        run_one(0, 4'h8, 4'h7, 1);
`else
        run_one(0, 4'h8, 4'h7, 2);
`endif

        // Back-pressure: only non-granted requesters show rsp_ready
        step();
        rsp_ready = 4'b1101;
        issue(1, 4'h5, 4'h5);
        req_valid = 4'b1101;
        @(negedge clk);
        check("bp_cmp_req_ready", int'(req_ready), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", int'(rsp_valid), 4'b0010);
            check("bp_result",    dut_res(),       4);
            check("bp_req_ready", int'(req_ready), 0);
        end
        step();
        rsp_ready = '1;
        @(negedge clk);
        check("bp_last_rsp", int'(rsp_valid), 4'b0010);
        @(negedge clk);
        check("bp_idle_busy",  int'(busy),      0);
        check("bp_idle_ready", int'(req_ready), 4'b0100);
        step();
        req_valid = '0;
        wait_idle();

        // Reset during CMP aborts the transaction and rewinds the pointer
        step();
        issue(1, 4'h3, 4'h3);
        rst = 1'b1;
        @(negedge clk);
        check("ab_busy",      int'(busy),      0);
        check("ab_rsp_valid", int'(rsp_valid), 0);
        check("ab_req_ready", int'(req_ready), 0);
        check("ab_grant_id",  int'(grant_id),  0);
        check("ab_result",    dut_res(),       0);
        step();
        rst = 1'b0;
        req_valid = 4'b1010;
        @(negedge clk);
        check("ab_regrant", int'(req_ready), 4'b0010);
        step();
        req_valid = '0;
        wait_idle();

        // Requester 3 wins over 1, operands change after the grant
        step();
        req_a[3*W +: W] = 4'h2;
        req_b[3*W +: W] = 4'h6;
        req_valid = 4'b1010;
        @(negedge clk);
        check("lt_winner", int'(req_ready), 4'b1000);
        step();
        req_valid = '0;
        req_a[3*W +: W] = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("lt_rsp_valid", int'(rsp_valid), 4'b1000);
        check("lt_result",    dut_res(),       1);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
